// File: rtl/sccb_sensor_responder.sv
// rtl/sccb_sensor_responder.sv - SCCB/I2C responder emulating the OV5640 control port
module sccb_sensor_responder #(
    parameter logic [7:0]  SENSOR_ADDR = 8'h78,
    parameter int          MEM_AW      = 8,
    parameter logic [15:0] CHIP_ID     = 16'h5640,
    parameter int          FILTER_LEN  = 3,
    parameter int          SDA_HOLD    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy,
    output logic [7:0]  nack_cnt
);

    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int FW        = $clog2(FILTER_LEN + 1);
    localparam int HW        = (SDA_HOLD < 2) ? 1 : $clog2(SDA_HOLD + 1);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_DEV        = 4'd1;
    localparam logic [3:0] ST_DEV_ACK    = 4'd2;
    localparam logic [3:0] ST_ADDR_H     = 4'd3;
    localparam logic [3:0] ST_ADDR_H_ACK = 4'd4;
    localparam logic [3:0] ST_ADDR_L     = 4'd5;
    localparam logic [3:0] ST_ADDR_L_ACK = 4'd6;
    localparam logic [3:0] ST_WDATA      = 4'd7;
    localparam logic [3:0] ST_WDATA_ACK  = 4'd8;
    localparam logic [3:0] ST_RDATA      = 4'd9;
    localparam logic [3:0] ST_RDATA_ACK  = 4'd10;
    localparam logic [3:0] ST_IGNORE     = 4'd11;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] stab_cnt [2];
    logic          scl_q;
    logic          sda_q;

    logic          scl_f;
    logic          sda_f;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;

    logic [3:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic [15:0]   ptr;
    logic          rd_mode;
    logic          ack_seen;
    logic          master_ack;
    logic          drive_next;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    mem [MEM_DEPTH];

    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {shreg[6:0], sda_f};

    // Synchronize both lines, then accept a new level only after it has held for FILTER_LEN cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            filt  <= 2'b11;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {sda_i, scl_i};
            sync2 <= sync1;
            scl_q <= filt[0];
            sda_q <= filt[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i]     <= sync2[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Byte served on reads: chip ID registers overlay the register file
    always_comb begin
        rd_byte = mem[ptr[MEM_AW-1:0]];
        if (ptr == 16'h300A) begin
            rd_byte = CHIP_ID[15:8];
        end else if (ptr == 16'h300B) begin
            rd_byte = CHIP_ID[7:0];
        end
    end

    // Protocol FSM: bits shift in on SCL rise; SDA drive decisions are made on SCL fall
    // and applied SDA_HOLD cycles later so the line never moves while SCL is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            rd_mode     <= 1'b0;
            ack_seen    <= 1'b0;
            master_ack  <= 1'b0;
            drive_next  <= 1'b0;
            hold_cnt    <= '0;
            sda_oe      <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            busy        <= 1'b0;
            nack_cnt    <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            reg_wr_en <= 1'b0;

            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == HW'(1)) begin
                    sda_oe <= drive_next;
                end
            end

            if (start_det || stop_det) begin
                // Any partial byte is dropped; a repeated START restarts address decode
                state      <= start_det ? ST_DEV : ST_IDLE;
                busy       <= start_det;
                bit_cnt    <= '0;
                ack_seen   <= 1'b0;
                drive_next <= 1'b0;
                hold_cnt   <= '0;
                sda_oe     <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_DEV, ST_ADDR_H, ST_ADDR_L, ST_WDATA: begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_seen <= 1'b0;
                            case (state)
                                ST_DEV: begin
                                    if (rx_byte == SENSOR_ADDR) begin
                                        state   <= ST_DEV_ACK;
                                        rd_mode <= 1'b0;
                                    end else if (rx_byte == (SENSOR_ADDR | 8'h01)) begin
                                        state   <= ST_DEV_ACK;
                                        rd_mode <= 1'b1;
                                    end else begin
                                        state <= ST_IGNORE;
                                        if (nack_cnt != 8'hFF) begin
                                            nack_cnt <= nack_cnt + 8'd1;
                                        end
                                    end
                                end
                                ST_ADDR_H: begin
                                    ptr[15:8] <= rx_byte;
                                    state     <= ST_ADDR_H_ACK;
                                end
                                ST_ADDR_L: begin
                                    ptr[7:0] <= rx_byte;
                                    state    <= ST_ADDR_L_ACK;
                                end
                                default: begin
                                    mem[ptr[MEM_AW-1:0]] <= rx_byte;
                                    reg_wr_en            <= 1'b1;
                                    reg_wr_addr          <= ptr;
                                    reg_wr_data          <= rx_byte;
                                    ptr                  <= ptr + 16'd1;
                                    state                <= ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state    <= ST_RDATA_ACK;
                            ack_seen <= 1'b0;
                        end
                    end
                    ST_DEV_ACK, ST_ADDR_H_ACK, ST_ADDR_L_ACK, ST_WDATA_ACK: begin
                        ack_seen <= 1'b1;
                    end
                    ST_RDATA_ACK: begin
                        ack_seen   <= 1'b1;
                        master_ack <= ~sda_f;
                        if (!sda_f) begin
                            ptr <= ptr + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (scl_fall) begin
                hold_cnt   <= HW'(SDA_HOLD);
                drive_next <= 1'b0;
                case (state)
                    ST_DEV_ACK, ST_ADDR_H_ACK, ST_ADDR_L_ACK, ST_WDATA_ACK: begin
                        if (!ack_seen) begin
                            drive_next <= 1'b1;
                        end else begin
                            bit_cnt <= '0;
                            case (state)
                                ST_DEV_ACK: begin
                                    if (rd_mode) begin
                                        shreg      <= rd_byte;
                                        drive_next <= ~rd_byte[7];
                                        state      <= ST_RDATA;
                                    end else begin
                                        state <= ST_ADDR_H;
                                    end
                                end
                                ST_ADDR_H_ACK: state <= ST_ADDR_L;
                                default:       state <= ST_WDATA;
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        drive_next <= ~shreg[7];
                    end
                    ST_RDATA_ACK: begin
                        if (ack_seen) begin
                            bit_cnt <= '0;
                            if (master_ack) begin
                                shreg      <= rd_byte;
                                drive_next <= ~rd_byte[7];
                                state      <= ST_RDATA;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_sensor_responder.sv
// tb/tb_sccb_sensor_responder.sv - randomized self-checking bench for sccb_sensor_responder
module tb_sccb_sensor_responder;

    localparam int Q = 16;

    logic        clk;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic        reg_wr_en;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy;
    logic [7:0]  nack_cnt;

    int total;
    int bad;

    logic [7:0]  mem_m [256];
    logic [15:0] ptr_m;
    int          nack_m;
    logic [23:0] exp_wr [$];
    logic [7:0]  wbuf [4];

    logic [15:0] got_a [256];
    logic [7:0]  got_d [256];
    int          got_cnt;
    int          rd_idx;
    int          oe_hi_cnt;
    int          oe_viol;
    logic        oe_prev;

    assign sda_bus = sda_m & ~sda_oe;

    sccb_sensor_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .busy       (busy),
        .nack_cnt   (nack_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record strobes, time spent driving SDA, and any SDA-drive change while SCL is high
    initial begin
        got_cnt   = 0;
        oe_hi_cnt = 0;
        oe_viol   = 0;
        oe_prev   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1) begin
                if (reg_wr_en === 1'b1 && got_cnt < 256) begin
                    got_a[got_cnt] = reg_wr_addr;
                    got_d[got_cnt] = reg_wr_data;
                    got_cnt++;
                end
                if (sda_oe === 1'b1) oe_hi_cnt++;
                if (scl_m && sda_oe !== oe_prev) oe_viol++;
            end
            oe_prev = sda_oe;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (a == 16'h300A) return 8'h56;
        if (a == 16'h300B) return 8'h40;
        return mem_m[a[7:0]];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        seen  = sda_bus;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 7; i > 7 - n; i--) clock_bit(b[i], s);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        send_bits(b, 8);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        logic ack;
        write_byte(b, ack);
        check(tag, ack, 1'b1);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~ack, s);
    endtask

    task automatic check_strobes();
        logic [23:0] e;
        check("wr_count", got_cnt - rd_idx, exp_wr.size());
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (rd_idx < got_cnt) begin
                check("wr_strobe", {got_a[rd_idx], got_d[rd_idx]}, e);
                rd_idx++;
            end
        end
        rd_idx = got_cnt;
    endtask

    task automatic tx_write(input logic [15:0] a, input int n);
        i2c_start();
        check("busy_high", busy, 1'b1);
        send(8'h78, "dev_ack");
        send(a[15:8], "addr_h_ack");
        send(a[7:0], "addr_l_ack");
        ptr_m = a;
        for (int i = 0; i < n; i++) begin
            send(wbuf[i], "data_ack");
            exp_wr.push_back({ptr_m, wbuf[i]});
            mem_m[ptr_m[7:0]] = wbuf[i];
            ptr_m = ptr_m + 16'd1;
        end
        i2c_stop();
        check("busy_low", busy, 1'b0);
        check_strobes();
    endtask

    task automatic tx_read(input logic set_addr, input logic [15:0] a, input int n);
        logic [7:0] d;
        i2c_start();
        if (set_addr) begin
            send(8'h78, "dev_ack");
            send(a[15:8], "addr_h_ack");
            send(a[7:0], "addr_l_ack");
            ptr_m = a;
            i2c_start();
        end
        send(8'h79, "dev_rd_ack");
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            check("rd_data", d, model_rd(ptr_m));
            if (i != n - 1) ptr_m = ptr_m + 16'd1;
        end
        i2c_stop();
        check("busy_low", busy, 1'b0);
        check_strobes();
    endtask

    initial begin
        logic       ack;
        int         snap;
        total  = 0;
        bad    = 0;
        rd_idx = 0;
        ptr_m  = 16'h0000;
        nack_m = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_wr_en", reg_wr_en, 1'b0);
        check("rst_wr_addr", reg_wr_addr, 16'h0000);
        check("rst_wr_data", reg_wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_nack_cnt", nack_cnt, 8'h00);
        rst_n = 1'b1;
        wait_clk(10);

        wbuf[0] = 8'h01;
        tx_write(16'h3108, 1);

        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
        tx_write(16'h4000, 3);
        tx_read(1'b1, 16'h4000, 3);

        wbuf[0] = 8'hFF;
        tx_write(16'h300A, 1);
        tx_read(1'b1, 16'h300A, 2);

        snap = oe_hi_cnt;
        i2c_start();
        write_byte(8'h42, ack);
        check("foreign_dev_ack", ack, 1'b0);
        write_byte(8'h31, ack);
        check("ignored_byte_ack", ack, 1'b0);
        i2c_stop();
        nack_m++;
        check("ignore_sda_oe", oe_hi_cnt - snap, 0);
        check("nack_cnt", nack_cnt, nack_m);
        check_strobes();

        i2c_start();
        send(8'h78, "dev_ack");
        send(8'h50, "addr_h_ack");
        send(8'h00, "addr_l_ack");
        ptr_m = 16'h5000;
        send_bits(8'hA5, 4);
        i2c_stop();
        check("cut_busy", busy, 1'b0);
        check_strobes();
        tx_read(1'b0, 16'h0000, 1);

        sda_m = 1'b0; wait_clk(1);
        sda_m = 1'b1; wait_clk(20);
        check("glitch_busy", busy, 1'b0);

        for (int it = 0; it < 6; it++) begin
            logic [15:0] a;
            int          n;
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                tx_write(a, n);
            end else begin
                tx_read($urandom_range(0, 2) != 0, a, n);
            end
        end
        check("nack_cnt_final", nack_cnt, nack_m);

        i2c_start();
        send_bits(8'h78, 8);
        sda_m = 1'b1;
        for (int i = 0; i < 3 * Q && sda_oe !== 1'b1; i++) wait_clk(1);
        check("ack_drive", sda_oe, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_sda", sda_oe, 1'b0);
        wait_clk(3);
        check("rst2_wr_en", reg_wr_en, 1'b0);
        check("rst2_wr_addr", reg_wr_addr, 16'h0000);
        check("rst2_wr_data", reg_wr_data, 8'h00);
        check("rst2_busy", busy, 1'b0);
        check("rst2_nack_cnt", nack_cnt, 8'h00);
        rst_n = 1'b1;
        rd_idx = got_cnt;
        nack_m = 0;
        ptr_m  = 16'h0000;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        scl_m = 1'b1; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        i2c_stop();
        check("post_rst_busy", busy, 1'b0);
        wbuf[0] = 8'h01;
        tx_write(16'h3108, 1);
        tx_read(1'b1, 16'h3107, 2);

        check("sda_change_scl_high", oe_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
